// File: rtl/seed_pkg.sv
// rtl/seed_pkg.sv - shared SEED datapath constants and sequencer state encoding
package seed_pkg;

  localparam int SEED_WORD_BYTES = 4;
  localparam int SEED_BYTE_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seed_state_e;

endpackage

// File: rtl/seed_serial_add32_adder.sv
// rtl/seed_serial_add32_adder.sv - combinational 8-bit byte adder stage (module adder)
module adder (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       c_in,
  output logic [7:0] Sum,
  output logic       c_out
);

  logic [8:0] total;

  // Plain ripple add; carry out is the ninth bit
  always_comb begin
    total = {1'b0, A} + {1'b0, B} + {8'd0, c_in};
    Sum   = total[7:0];
    c_out = total[8];
  end

endmodule

// File: rtl/seed_serial_add32.sv
// rtl/seed_serial_add32.sv - byte-serial word adder sequencer; optional subtract via SEED_SERIAL_SUB_EN
module seed_serial_add32
  import seed_pkg::*;
#(
  parameter int NBYTES = SEED_WORD_BYTES,
  parameter int CNT_W  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NBYTES*SEED_BYTE_W-1:0] in_a,
  input  logic [NBYTES*SEED_BYTE_W-1:0] in_b,
`ifdef SEED_SERIAL_SUB_EN
  input  logic                          op_sub,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NBYTES*SEED_BYTE_W-1:0] out_sum,
  output logic                          out_carry,
  output logic                          busy
);

  localparam int W = NBYTES * SEED_BYTE_W;

  seed_state_e            state_q, state_d;
  logic [W-1:0]           a_q, a_d;
  logic [W-1:0]           b_q, b_d;
  // Upper W-8 bits of the partial sum; the newest byte enters at the top
  logic [W-SEED_BYTE_W-1:0] sum_q, sum_d;
  logic                   carry_q, carry_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [W-1:0]           out_sum_q, out_sum_d;
  logic                   out_carry_q, out_carry_d;

  logic [SEED_BYTE_W-1:0] byte_a, byte_b, byte_sum;
  logic                   byte_cout;
  logic                   load_cin;
  logic                   accept;
  logic [W-1:0]           full_sum;

`ifdef SEED_SERIAL_SUB_EN
  logic sub_q, sub_d;

  // Operation select is captured on accept and held for the whole word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sub_q <= 1'b0;
    else        sub_q <= sub_d;
  end

  // Subtract is A + ~B + 1: invert each B byte and seed the chain with 1
  assign byte_b   = b_q[SEED_BYTE_W-1:0] ^ {SEED_BYTE_W{sub_q}};
  assign load_cin = op_sub;
`else
  assign byte_b   = b_q[SEED_BYTE_W-1:0];
  assign load_cin = 1'b0;
`endif

  assign byte_a   = a_q[SEED_BYTE_W-1:0];
  assign full_sum = {byte_sum, sum_q};

  adder u_adder (
    .A     (byte_a),
    .B     (byte_b),
    .c_in  (carry_q),
    .Sum   (byte_sum),
    .c_out (byte_cout)
  );

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_carry = out_carry_q;
  assign busy      = (state_q == RUN);

  // Next-state, operand shifting and result capture
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
`ifdef SEED_SERIAL_SUB_EN
    sub_d       = sub_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = byte_cout;
        sum_d   = full_sum[W-1:SEED_BYTE_W];
        a_d     = a_q >> SEED_BYTE_W;
        b_d     = b_q >> SEED_BYTE_W;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NBYTES - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_sum_d   = full_sum;
          out_carry_d = byte_cout;
        end
      end
      DONE: begin
        // The old result stays on out_sum until the next word completes
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = accept ? RUN : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Operand load shared by the IDLE and DONE accept paths
    if (accept) begin
      a_d     = in_a;
      b_d     = in_b;
      carry_d = load_cin;
      cnt_d   = '0;
`ifdef SEED_SERIAL_SUB_EN
      sub_d   = op_sub;
`endif
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
    end
  end

endmodule

// File: tb/tb_seed_serial_add32.sv
// tb/tb_seed_serial_add32.sv - directed self-checking bench for seed_serial_add32
module tb_seed_serial_add32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_carry;
  logic        busy;

  int total;
  int bad;

  seed_serial_add32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef SEED_SERIAL_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: present one operand pair, wait for out_valid (bounded),
  // report latency in cycles after the accept edge and cycles busy was seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        output int lat, output int busy_cnt, output logic ready_seen);
    @(negedge clk);
    in_a      = a;
    in_b      = b;
    op_sub    = sub;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    ready_seen = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = -1;
    busy_cnt = 0;
    if (busy) busy_cnt++;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; op_sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (out_sum !== 32'h0)  begin bad++; $display("FAIL reset_out_sum got=%h exp=00000000", out_sum); end
    total++; if (out_carry !== 1'b0) begin bad++; $display("FAIL reset_out_carry got=%b exp=0", out_carry); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bc; logic rdy;
    run_op(32'h00000001, 32'h00000002, 1'b0, lat, bc, rdy);
    total++; if (rdy !== 1'b1)          begin bad++; $display("FAIL basic_in_ready got=%b exp=1", rdy); end
    total++; if (lat != 4)              begin bad++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    total++; if (bc != 4)               begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=4", bc); end
    total++; if (out_sum !== 32'h3)     begin bad++; $display("FAIL basic_sum got=%h exp=00000003", out_sum); end
    total++; if (out_carry !== 1'b0)    begin bad++; $display("FAIL basic_carry got=%b exp=0", out_carry); end
    total++; if (busy !== 1'b0)         begin bad++; $display("FAIL basic_busy_done got=%b exp=0", busy); end
    drain();
    total++; if (out_valid !== 1'b0)    begin bad++; $display("FAIL basic_drain_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1)     begin bad++; $display("FAIL basic_drain_idle got=%b exp=1", in_ready); end
  endtask

  task automatic test_carry();
    int lat, bc; logic rdy;
    run_op(32'h000000FF, 32'h00000001, 1'b0, lat, bc, rdy);
    total++; if (out_sum !== 32'h00000100) begin bad++; $display("FAIL carry1_sum got=%h exp=00000100", out_sum); end
    total++; if (out_carry !== 1'b0)       begin bad++; $display("FAIL carry1_carry got=%b exp=0", out_carry); end
    drain();
    run_op(32'h00FFFFFF, 32'h00000001, 1'b0, lat, bc, rdy);
    total++; if (out_sum !== 32'h01000000) begin bad++; $display("FAIL carry2_sum got=%h exp=01000000", out_sum); end
    total++; if (out_carry !== 1'b0)       begin bad++; $display("FAIL carry2_carry got=%b exp=0", out_carry); end
    total++; if (lat != 4)                 begin bad++; $display("FAIL carry2_latency got=%0d exp=4", lat); end
    drain();
  endtask

  task automatic test_wrap();
    int lat, bc; logic rdy;
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, lat, bc, rdy);
    total++; if (out_sum !== 32'h0)  begin bad++; $display("FAIL wrap1_sum got=%h exp=00000000", out_sum); end
    total++; if (out_carry !== 1'b1) begin bad++; $display("FAIL wrap1_carry got=%b exp=1", out_carry); end
    drain();
    run_op(32'h80000000, 32'h80000000, 1'b0, lat, bc, rdy);
    total++; if (out_sum !== 32'h0)  begin bad++; $display("FAIL wrap2_sum got=%h exp=00000000", out_sum); end
    total++; if (out_carry !== 1'b1) begin bad++; $display("FAIL wrap2_carry got=%b exp=1", out_carry); end
    drain();
    // Carry from a previous word must not leak into the next one
    run_op(32'h00000001, 32'h00000001, 1'b0, lat, bc, rdy);
    total++; if (out_sum !== 32'h2)  begin bad++; $display("FAIL wrap_noleak_sum got=%h exp=00000002", out_sum); end
    total++; if (out_carry !== 1'b0) begin bad++; $display("FAIL wrap_noleak_carry got=%b exp=0", out_carry); end
    drain();
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic rdy;
    run_op(32'h0F0F0F0F, 32'h01010101, 1'b0, lat, bc, rdy);
    total++; if (out_sum !== 32'h10101010) begin bad++; $display("FAIL bp_first_sum got=%h exp=10101010", out_sum); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 2);
      in_a = 32'hAAAAAAAA; in_b = 32'h55555555;
      #1;
      total++; if (in_ready !== 1'b0)        begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      total++; if (out_valid !== 1'b1)       begin bad++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid); end
      total++; if (out_sum !== 32'h10101010) begin bad++; $display("FAIL bp_hold_sum cyc=%0d got=%h exp=10101010", i, out_sum); end
      total++; if (out_carry !== 1'b0)       begin bad++; $display("FAIL bp_hold_carry cyc=%0d got=%b exp=0", i, out_carry); end
    end
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h12345678; in_b = 32'h11111111; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (out_valid !== 1'b0)       begin bad++; $display("FAIL b2b_valid_drop got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b1)            begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    total++; if (out_sum !== 32'h10101010) begin bad++; $display("FAIL b2b_old_sum got=%h exp=10101010", out_sum); end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin lat = i; break; end
    end
    total++; if (lat != 4)                 begin bad++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
    total++; if (out_sum !== 32'h23456789) begin bad++; $display("FAIL b2b_sum got=%h exp=23456789", out_sum); end
    total++; if (out_carry !== 1'b0)       begin bad++; $display("FAIL b2b_carry got=%b exp=0", out_carry); end
    drain();
  endtask

  task automatic test_reset_mid();
    int lat, bc; logic rdy;
    @(negedge clk);
    in_a = 32'h11223344; in_b = 32'h55667788; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    total++; if (out_sum !== 32'h0)  begin bad++; $display("FAIL rstmid_out_sum got=%h exp=00000000", out_sum); end
    total++; if (out_carry !== 1'b0) begin bad++; $display("FAIL rstmid_out_carry got=%b exp=0", out_carry); end
    @(negedge clk);
    rst_n = 1'b1;
    // A stale in-flight word would surface here if it were not discarded
    repeat (6) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale_valid got=%b exp=0", out_valid); end
    run_op(32'hDEADBEEF, 32'h01010101, 1'b0, lat, bc, rdy);
    total++; if (lat != 4)                 begin bad++; $display("FAIL rstmid_latency got=%0d exp=4", lat); end
    total++; if (out_sum !== 32'hDFAEBFF0) begin bad++; $display("FAIL rstmid_sum got=%h exp=DFAEBFF0", out_sum); end
    total++; if (out_carry !== 1'b0)       begin bad++; $display("FAIL rstmid_carry got=%b exp=0", out_carry); end
    drain();
  endtask

`ifdef SEED_SERIAL_SUB_EN
  task automatic test_sub();
    int lat, bc; logic rdy;
    run_op(32'h00000000, 32'h00000001, 1'b1, lat, bc, rdy);
    total++; if (out_sum !== 32'hFFFFFFFF) begin bad++; $display("FAIL sub1_sum got=%h exp=FFFFFFFF", out_sum); end
    total++; if (out_carry !== 1'b0)       begin bad++; $display("FAIL sub1_carry got=%b exp=0", out_carry); end
    drain();
    run_op(32'h00000100, 32'h00000001, 1'b1, lat, bc, rdy);
    total++; if (out_sum !== 32'h000000FF) begin bad++; $display("FAIL sub2_sum got=%h exp=000000FF", out_sum); end
    total++; if (out_carry !== 1'b1)       begin bad++; $display("FAIL sub2_carry got=%b exp=1", out_carry); end
    drain();
    run_op(32'h00000005, 32'h00000003, 1'b0, lat, bc, rdy);
    total++; if (out_sum !== 32'h00000008) begin bad++; $display("FAIL sub_addback_sum got=%h exp=00000008", out_sum); end
    drain();
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_carry();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef SEED_SERIAL_SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
